// File: rtl/aes_key_expander.sv
// AES key expansion engine for 128/192/256-bit keys. It produces one schedule word per cycle
// into a word store, then serves any round key by index with single-cycle read latency.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      p  = p ^ (b[k] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as b^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = b;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Forward S-box substitution.
  always_comb begin
    out_byte = affine(gf_inv(in_byte));
  end

endmodule

module aes_key_expander #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RND_IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic [MAX_KEY_BITS-1:0] key_i,
  output logic                    busy_o,
  output logic                    keys_valid_o,
  output logic                    mode_err_o,
  output logic [3:0]              num_rounds_o,
  input  logic                    rd_en_i,
  input  logic [RND_IDX_W-1:0]    rd_round_i,
  output logic [127:0]            rk_o,
  output logic                    rk_vld_o,
  output logic                    rd_err_o
);

  localparam int MAX_NK    = MAX_KEY_BITS / 32;
  localparam int MAX_WORDS = 4 * (MAX_NK + 7);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [1:0]  state;
  logic [31:0] store [MAX_WORDS];
  logic [5:0]  word_idx;
  logic [2:0]  word_mod;
  logic [7:0]  rcon;
  logic [5:0]  nk;
  logic [3:0]  nr;
  logic [5:0]  total;

  logic        mode_ok;
  logic [5:0]  sel_nk;
  logic [3:0]  sel_nr;
  logic [5:0]  sel_total;
  logic        start_ok;
  logic        accept;

  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_word;

  logic        rd_ok;
  logic [5:0]  rd_base;

  // Key-size decode; sizes beyond the build-time maximum are treated as illegal.
  always_comb begin
    mode_ok   = 1'b0;
    sel_nk    = 6'd4;
    sel_nr    = 4'd10;
    sel_total = 6'd44;
    case (mode_i)
      2'd0: begin
        mode_ok = 1'b1;
      end
      2'd1: begin
        mode_ok   = (MAX_KEY_BITS >= 192);
        sel_nk    = 6'd6;
        sel_nr    = 4'd12;
        sel_total = 6'd52;
      end
      2'd2: begin
        mode_ok   = (MAX_KEY_BITS >= 256);
        sel_nk    = 6'd8;
        sel_nr    = 4'd14;
        sel_total = 6'd60;
      end
      default: begin
        mode_ok = 1'b0;
      end
    endcase
  end

  // Start qualification: starts during expansion are silently dropped.
  always_comb begin
    start_ok = start_i && (state != ST_EXPAND);
    accept   = start_ok && mode_ok;
  end

  // Next schedule word from w[i-1] and w[i-Nk].
  always_comb begin
    prev_word = store[word_idx - 6'd1];
    back_word = store[word_idx - nk];
    sub_in    = (word_mod == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (word_mod == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((nk == 6'd8) && (word_mod == 3'd4)) begin
      temp = sub_out;
    end else begin
      temp = prev_word;
    end
    new_word = back_word ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  // Control FSM, expansion counters and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      mode_err_o   <= 1'b0;
      num_rounds_o <= 4'd0;
      word_idx     <= 6'd0;
      word_mod     <= 3'd0;
      rcon         <= 8'h01;
      nk           <= 6'd4;
      nr           <= 4'd10;
      total        <= 6'd44;
    end else begin
      mode_err_o <= start_ok && !mode_ok;
      case (state)
        ST_IDLE, ST_READY: begin
          if (accept) begin
            state        <= ST_EXPAND;
            busy_o       <= 1'b1;
            keys_valid_o <= 1'b0;
            num_rounds_o <= 4'd0;
            word_idx     <= sel_nk;
            word_mod     <= 3'd0;
            rcon         <= 8'h01;
            nk           <= sel_nk;
            nr           <= sel_nr;
            total        <= sel_total;
          end
        end
        ST_EXPAND: begin
          word_idx <= word_idx + 6'd1;
          word_mod <= (word_mod == 3'(nk - 6'd1)) ? 3'd0 : word_mod + 3'd1;
          if (word_mod == 3'd0) begin
            rcon <= xtime(rcon);
          end
          if (word_idx == total - 6'd1) begin
            state        <= ST_READY;
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b1;
            num_rounds_o <= nr;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Word store: key words on the accepting edge, one expanded word per cycle after that.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (6'(j) < sel_nk) begin
          store[j] <= key_i[MAX_KEY_BITS-1-32*j -: 32];
        end
      end
    end else if (state == ST_EXPAND) begin
      store[word_idx] <= new_word;
    end
  end

  // Read address and range check against the stored schedule.
  always_comb begin
    rd_ok   = keys_valid_o && (32'(rd_round_i) <= 32'(num_rounds_o));
    rd_base = 6'({rd_round_i, 2'b00});
  end

  // Round-key read port; a rejected read leaves rk_o untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_o     <= 128'd0;
      rk_vld_o <= 1'b0;
      rd_err_o <= 1'b0;
    end else if (rd_en_i) begin
      if (rd_ok) begin
        rk_o     <= {store[rd_base], store[rd_base + 6'd1], store[rd_base + 6'd2], store[rd_base + 6'd3]};
        rk_vld_o <= 1'b1;
        rd_err_o <= 1'b0;
      end else begin
        rk_vld_o <= 1'b0;
        rd_err_o <= 1'b1;
      end
    end else begin
      rk_vld_o <= 1'b0;
      rd_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors, random keys checked against a
// word-array reference expansion, error paths, mid-run reset and restart.

module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy, keys_valid, mode_err, rk_vld, rd_err, rd_en;
  logic [3:0]   num_rounds, rd_round;
  logic [127:0] rk;

  logic         s_start, s_busy, s_keys_valid, s_mode_err, s_rk_vld, s_rd_err, s_rd_en;
  logic [1:0]   s_mode;
  logic [127:0] s_key, s_rk;
  logic [3:0]   s_num_rounds, s_rd_round;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_expander #(.MAX_KEY_BITS(256), .RND_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .key_i(key),
    .busy_o(busy), .keys_valid_o(keys_valid), .mode_err_o(mode_err), .num_rounds_o(num_rounds),
    .rd_en_i(rd_en), .rd_round_i(rd_round), .rk_o(rk), .rk_vld_o(rk_vld), .rd_err_o(rd_err)
  );

  aes_key_expander #(.MAX_KEY_BITS(128), .RND_IDX_W(4)) dut_small (
    .clk(clk), .rst(rst), .start_i(s_start), .mode_i(s_mode), .key_i(s_key),
    .busy_o(s_busy), .keys_valid_o(s_keys_valid), .mode_err_o(s_mode_err), .num_rounds_o(s_num_rounds),
    .rd_en_i(s_rd_en), .rd_round_i(s_rd_round), .rk_o(s_rk), .rk_vld_o(s_rk_vld), .rd_err_o(s_rd_err)
  );

  // Reference model state.
  logic [7:0]  sbox_t [0:255];
  logic [7:0]  rcon_t [0:9];
  logic [31:0] ref_w  [0:59];
  int          ref_nr;
  int          ref_nk;

  // S-box built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] k, input int m);
    logic [31:0] t;
    ref_nk = 4 + 2 * m;
    ref_nr = ref_nk + 6;
    for (int i = 0; i < ref_nk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = ref_nk; i < 4 * (ref_nr + 1); i++) begin
      t = ref_w[i-1];
      if (i % ref_nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon_t[i/ref_nk - 1], 24'h0};
      else if (ref_nk == 8 && i % ref_nk == 4)
        t = sub_word(t);
      ref_w[i] = ref_w[i-ref_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_of(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [255:0] k);
    start = 1'b1;
    mode  = m;
    key   = k;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!keys_valid && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_read(input int r);
    rd_en    = 1'b1;
    rd_round = 4'(r);
    tick();
    rd_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mode = 2'd0; key = '0; rd_en = 1'b0; rd_round = 4'd0;
    s_start = 1'b0; s_mode = 2'd0; s_key = '0; s_rd_en = 1'b0; s_rd_round = 4'd0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, keys_valid, mode_err, rk_vld, rd_err, num_rounds, rk} !== 136'd0)
      $display("FAIL reset_outputs: got %h required 0", {busy, keys_valid, mode_err, rk_vld, rd_err, num_rounds, rk});
    else n_pass++;
    n_checks++;
    if ({s_busy, s_keys_valid, s_mode_err, s_rk_vld, s_rd_err, s_num_rounds, s_rk} !== 136'd0)
      $display("FAIL reset_outputs_small: got %h required 0", {s_busy, s_keys_valid, s_mode_err, s_rk_vld, s_rd_err, s_num_rounds, s_rk});
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    tick();
    do_read(0);
    n_checks++;
    if ({rd_err, rk_vld} !== 2'b10) $display("FAIL read_after_reset: got err/vld %b required 10", {rd_err, rk_vld});
    else n_pass++;
  endtask

  task automatic test_aes128_kat();
    int c;
    ref_expand(KEY128, 0);
    do_start(2'd0, KEY128);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b required 1", busy); else n_pass++;
    wait_valid(c);
    n_checks++;
    if (c !== 40) $display("FAIL latency128: got %0d required 40", c); else n_pass++;
    n_checks++;
    if (num_rounds !== 4'd10 || busy !== 1'b0) $display("FAIL nr128: got nr %0d busy %b required 10 0", num_rounds, busy); else n_pass++;
    for (int r = 0; r <= 10; r++) begin
      rd_en = 1'b1;
      rd_round = 4'(r);
      tick();
      n_checks++;
      if (rk_vld !== 1'b1 || rk !== rk_of(r)) $display("FAIL b2b128_r%0d: got %b %h required 1 %h", r, rk_vld, rk, rk_of(r));
      else n_pass++;
    end
    rd_en = 1'b0;
    do_read(1);
    n_checks++;
    if (rk !== RK128_1) $display("FAIL kat128_r1: got %h required %h", rk, RK128_1); else n_pass++;
    do_read(10);
    n_checks++;
    if (rk !== RK128_10) $display("FAIL kat128_r10: got %h required %h", rk, RK128_10); else n_pass++;
    do_read(11);
    n_checks++;
    if (rd_err !== 1'b1 || rk_vld !== 1'b0 || rk !== RK128_10)
      $display("FAIL read_r11_128: got err %b vld %b rk %h required 1 0 %h", rd_err, rk_vld, rk, RK128_10);
    else n_pass++;
    tick();
    n_checks++;
    if (rd_err !== 1'b0) $display("FAIL rd_err_pulse: got %b required 0", rd_err); else n_pass++;
  endtask

  task automatic test_aes192_kat();
    int c;
    ref_expand(KEY192, 1);
    do_start(2'd1, KEY192);
    wait_valid(c);
    n_checks++;
    if (c !== 46 || num_rounds !== 4'd12) $display("FAIL latency192: got %0d nr %0d required 46 12", c, num_rounds); else n_pass++;
    do_read(12);
    n_checks++;
    if (rk_vld !== 1'b1 || rk !== RK192_12) $display("FAIL kat192_r12: got %h required %h", rk, RK192_12); else n_pass++;
    for (int r = 0; r <= 12; r++) begin
      do_read(r);
      n_checks++;
      if (rk !== rk_of(r)) $display("FAIL model192_r%0d: got %h required %h", r, rk, rk_of(r)); else n_pass++;
    end
    do_read(13);
    n_checks++;
    if (rd_err !== 1'b1 || rk_vld !== 1'b0) $display("FAIL read_r13_192: got err %b vld %b required 1 0", rd_err, rk_vld); else n_pass++;
  endtask

  task automatic test_aes256_reverse();
    int c;
    int pulses;
    ref_expand(KEY256, 2);
    do_start(2'd2, KEY256);
    wait_valid(c);
    n_checks++;
    if (c !== 52 || num_rounds !== 4'd14) $display("FAIL latency256: got %0d nr %0d required 52 14", c, num_rounds); else n_pass++;
    pulses = 0;
    for (int r = 14; r >= 0; r--) begin
      rd_en = 1'b1;
      rd_round = 4'(r);
      tick();
      if (rk_vld === 1'b1) pulses++;
      n_checks++;
      if (rk !== rk_of(r)) $display("FAIL rev256_r%0d: got %h required %h", r, rk, rk_of(r)); else n_pass++;
      if (r == 14) begin
        n_checks++;
        if (rk !== RK256_14) $display("FAIL kat256_r14: got %h required %h", rk, RK256_14); else n_pass++;
      end
    end
    rd_en = 1'b0;
    n_checks++;
    if (pulses !== 15) $display("FAIL rev256_pulses: got %0d required 15", pulses); else n_pass++;
    do_read(15);
    n_checks++;
    if (rd_err !== 1'b1 || rk !== rk_of(0)) $display("FAIL read_r15_256: got err %b rk %h required 1 %h", rd_err, rk, rk_of(0)); else n_pass++;
  endtask

  task automatic test_mode_errors();
    do_start(2'd3, KEY128);
    n_checks++;
    if ({mode_err, keys_valid, busy, num_rounds} !== {3'b110, 4'd14})
      $display("FAIL mode3_ready: got err/valid/busy/nr %b %b %b %0d required 1 1 0 14", mode_err, keys_valid, busy, num_rounds);
    else n_pass++;
    tick();
    n_checks++;
    if (mode_err !== 1'b0) $display("FAIL mode_err_pulse: got %b required 0", mode_err); else n_pass++;
    do_read(14);
    n_checks++;
    if (rk !== RK256_14) $display("FAIL store_kept_after_err: got %h required %h", rk, RK256_14); else n_pass++;
  endtask

  task automatic test_same_edge_read();
    int c;
    start = 1'b1; mode = 2'd0; key = KEY128;
    rd_en = 1'b1; rd_round = 4'd14;
    tick();
    start = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (rk_vld !== 1'b1 || rk !== RK256_14 || keys_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL same_edge_read: got vld %b rk %h valid %b busy %b required 1 %h 0 1", rk_vld, rk, keys_valid, busy, RK256_14);
    else n_pass++;
    do_read(0);
    n_checks++;
    if (rd_err !== 1'b1 || rk_vld !== 1'b0 || rk !== RK256_14)
      $display("FAIL read_during_expand: got err %b vld %b rk %h required 1 0 %h", rd_err, rk_vld, rk, RK256_14);
    else n_pass++;
    wait_valid(c);
    n_checks++;
    if (c + 1 !== 40) $display("FAIL restart_latency: got %0d required 40", c + 1); else n_pass++;
    do_read(10);
    n_checks++;
    if (rk !== RK128_10) $display("FAIL restart_r10: got %h required %h", rk, RK128_10); else n_pass++;
  endtask

  task automatic test_start_during_expand();
    int c;
    ref_expand(KEY192, 1);
    do_start(2'd1, KEY192);
    for (int k = 0; k < 4; k++) tick();
    start = 1'b1; mode = 2'd0; key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    tick();
    mode = 2'd3;
    tick();
    start = 1'b0;
    n_checks++;
    if (mode_err !== 1'b0 || busy !== 1'b1) $display("FAIL start_in_expand: got err %b busy %b required 0 1", mode_err, busy); else n_pass++;
    wait_valid(c);
    n_checks++;
    if (c + 6 !== 46 || num_rounds !== 4'd12) $display("FAIL ignored_start_latency: got %0d nr %0d required 46 12", c + 6, num_rounds); else n_pass++;
    for (int r = 0; r <= 12; r++) begin
      do_read(r);
      n_checks++;
      if (rk !== rk_of(r)) $display("FAIL ignored_start_r%0d: got %h required %h", r, rk, rk_of(r)); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int c;
    do_start(2'd2, KEY256);
    for (int k = 0; k < 19; k++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, keys_valid, mode_err, rk_vld, rd_err, num_rounds, rk} !== 136'd0)
      $display("FAIL mid_reset: got %h required 0", {busy, keys_valid, mode_err, rk_vld, rd_err, num_rounds, rk});
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || keys_valid !== 1'b0) $display("FAIL idle_after_reset: got busy %b valid %b required 0 0", busy, keys_valid); else n_pass++;
    do_start(2'd0, KEY128);
    wait_valid(c);
    n_checks++;
    if (c !== 40) $display("FAIL post_reset_latency: got %0d required 40", c); else n_pass++;
    do_read(10);
    n_checks++;
    if (rk !== RK128_10) $display("FAIL post_reset_r10: got %h required %h", rk, RK128_10); else n_pass++;
  endtask

  task automatic test_max128();
    int c;
    logic [1:0] bad_modes [0:2];
    bad_modes = '{2'd3, 2'd2, 2'd1};
    for (int k = 0; k < 3; k++) begin
      s_start = 1'b1; s_mode = bad_modes[k]; s_key = KEY128[255:128];
      tick();
      s_start = 1'b0;
      n_checks++;
      if (s_mode_err !== 1'b1 || s_busy !== 1'b0 || s_keys_valid !== 1'b0)
        $display("FAIL small_mode%0d: got err %b busy %b valid %b required 1 0 0", bad_modes[k], s_mode_err, s_busy, s_keys_valid);
      else n_pass++;
      tick();
    end
    s_start = 1'b1; s_mode = 2'd0;
    tick();
    s_start = 1'b0;
    c = 0;
    while (!s_keys_valid && c < 200) begin
      tick();
      c++;
    end
    n_checks++;
    if (c !== 40 || s_num_rounds !== 4'd10) $display("FAIL small_latency: got %0d nr %0d required 40 10", c, s_num_rounds); else n_pass++;
    s_rd_en = 1'b1; s_rd_round = 4'd10;
    tick();
    s_rd_en = 1'b0;
    n_checks++;
    if (s_rk_vld !== 1'b1 || s_rk !== RK128_10) $display("FAIL small_r10: got %b %h required 1 %h", s_rk_vld, s_rk, RK128_10); else n_pass++;
  endtask

  task automatic test_random();
    int c, m, rr;
    logic [255:0] k;
    for (int it = 0; it < 4; it++) begin
      m = $urandom_range(0, 2);
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ref_expand(k, m);
      do_start(2'(m), k);
      wait_valid(c);
      n_checks++;
      if (c !== 4 * (ref_nr + 1) - ref_nk || num_rounds !== 4'(ref_nr))
        $display("FAIL rand%0d_latency: got %0d nr %0d required %0d %0d", it, c, num_rounds, 4 * (ref_nr + 1) - ref_nk, ref_nr);
      else n_pass++;
      for (int j = 0; j < 6; j++) begin
        rr = $urandom_range(0, ref_nr);
        rd_en = 1'b1;
        rd_round = 4'(rr);
        tick();
        n_checks++;
        if (rk_vld !== 1'b1 || rk !== rk_of(rr)) $display("FAIL rand%0d_r%0d: got %b %h required 1 %h", it, rr, rk_vld, rk, rk_of(rr));
        else n_pass++;
      end
      rd_en = 1'b0;
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_aes128_kat();
    test_aes192_kat();
    test_aes256_reverse();
    test_mode_errors();
    test_same_edge_read();
    test_start_during_expand();
    test_mid_reset();
    test_max128();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised AES key expansion engine that succeeds the fixed AES-128, one-key-per-round schedule. It supports 128/192/256-bit keys (FIPS-197), selectable per start up to a build-time maximum. It computes one 32-bit schedule word per cycle into an internal round-key store, then serves any round key by index, forward or reverse, so the same expansion feeds both encrypt and decrypt datapaths of the AES core.

## Interface
Parameters:
- MAX_KEY_BITS, 256, largest supported key (128, 192 or 256); sizes the key port and the store (4*(Nr_max+1) words: 44/52/60)
- RND_IDX_W, 4, width of the round index port

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request expansion; accepted only when busy_o=0
- mode_i  in  2  key size sampled with start_i: 0=128, 1=192, 2=256, 3=illegal
- key_i  in  MAX_KEY_BITS  cipher key, MSB-first; 128/192-bit keys occupy the top bits, unused low bits ignored
- busy_o  out  1  expansion in progress
- keys_valid_o  out  1  full schedule stored and readable
- mode_err_o  out  1  one-cycle pulse: start with illegal mode or mode exceeding MAX_KEY_BITS
- num_rounds_o  out  4  Nr of the stored schedule (10/12/14), 0 when none valid
- rd_en_i  in  1  round-key read request
- rd_round_i  in  RND_IDX_W  round index 0..Nr
- rk_o  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
- rk_vld_o  out  1  one-cycle pulse: rk_o holds the requested key
- rd_err_o  out  1  one-cycle pulse: read rejected

## Operation
- Nk=4/6/8, Nr=10/12/14, total words W=4*(Nr+1)=44/52/60.
- States: IDLE, EXPAND, READY.
- IDLE/READY + start_i, legal mode: write w[0..Nk-1] from key_i in the same edge; latch mode; i<=Nk; rcon<=8'h01; keys_valid_o<=0; num_rounds_o<=0; -> EXPAND.
- IDLE/READY + start_i, illegal mode: mode_err_o pulse; store, keys_valid_o and num_rounds_o unchanged; state unchanged.
- EXPAND, each cycle, with temp=w[i-1]:
  - i mod Nk==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}, then rcon<=xtime(rcon) (0x80->0x1B).
  - Nk==8 and i mod 8==4: temp=SubWord(temp).
  - w[i]<=w[i-Nk]^temp; i<=i+1.
  - On the cycle writing w[W-1]: -> READY; keys_valid_o<=1; num_rounds_o<=Nr.
- start_i during EXPAND: ignored, no error, no effect.
- Reads: rd_en_i sampled each edge.
  - keys_valid_o=1 and rd_round_i<=Nr: next cycle rk_o=round key, rk_vld_o=1.
  - Otherwise: rd_err_o=1, rk_vld_o=0, rk_o holds its previous value.
  - Reads are independent of start_i. A read accepted on the same edge as a new start returns the old schedule, because the store is overwritten only from that edge.
- Reverse order for decryption is the caller's choice of indices (Nr down to 0). No extra mode is needed.
- SubWord uses four instances of the codebase sbox.

## Timing
- Reset (async, any state, including mid-EXPAND):
  - State=IDLE; busy_o, keys_valid_o, mode_err_o, rk_vld_o, rd_err_o=0; num_rounds_o=0; rk_o=0; i=0; rcon=8'h01.
  - Store contents are don't-care and are unreadable until the next completed expansion.
- Start accepted at edge E0:
  - busy_o=1 after E0.
  - keys_valid_o=1 and busy_o=0 after E0+N, with N=W-Nk=40/46/52 for 128/192/256.
- New start from READY: keys_valid_o falls after the accepting edge, so no stale/new mix is ever readable.
- Read latency: 1 cycle. Back-to-back reads return one key per cycle.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
  - keys_valid_o rises 40 cycles after start; num_rounds_o=10.
  - Round 1 reads a0fafe1788542cb123a339392a6c7605.
  - Round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - Valid after 46 cycles.
  - Round 12 reads e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Valid after 52 cycles.
  - Round 14 reads fe4890d1e6188d0b046df344706c631e.
  - Reverse reads 14..0 over 15 consecutive cycles give 15 rk_vld_o pulses.
- Errors:
  - mode_i=3 -> mode_err_o pulse, state stays IDLE.
  - mode_i=2 with MAX_KEY_BITS=128 -> mode_err_o.
  - Read round 11 in 128 mode -> rd_err_o.
  - Read during EXPAND -> rd_err_o.
- Mid-operation events:
  - Assert rst at cycle 20 of an AES-256 expansion -> all outputs 0 immediately.
  - Restart with the AES-128 key -> correct round 10 after 40 cycles.
  - start_i during EXPAND -> ignored, original schedule completes unchanged.
